// File: rtl/frac_clk_div.sv
// frac_clk_div: phase-accumulator (DDS) fractional clock divider.
// clkout is the MSB of an ACC_W-bit accumulator stepped by div each clkin.
module frac_clk_div #(
   parameter int ACC_W = 32
) (
   input  logic             clkin,
   input  logic             reset_n,
   input  logic [ACC_W-1:0] div,
   output logic             clkout
);

   logic [ACC_W-1:0] div_q;
   logic [ACC_W-1:0] acc;

   // capture the tuning word so div never reaches clkout combinationally
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
      end else begin
         div_q <= div;
      end
   end

   // phase accumulator; the carry out is dropped so it wraps mod 2^ACC_W
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else begin
         acc <= acc + div_q;
      end
   end

   assign clkout = acc[ACC_W-1];

endmodule

// File: tb/tb_frac_clk_div.sv
// tb_frac_clk_div: scoreboard bench for frac_clk_div.
// Expected accumulator values are queued as div is driven, popped after each edge.
module tb_frac_clk_div;

   localparam int W = 32;

   logic         clkin;
   logic         reset_n;
   logic [W-1:0] div;
   logic         clkout;

   frac_clk_div #(.ACC_W(W)) dut (
      .clkin   (clkin),
      .reset_n (reset_n),
      .div     (div),
      .clkout  (clkout)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] m_div_q;
   logic [W-1:0] m_acc;
   logic [W-1:0] exp_q[$];

   logic trk_prev;
   int   ph_len;
   int   min_ph;
   int   rises;
   int   since;
   int   last_per;
   bit   have_rise;
   bit   seen_edge;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic track_reset();
      trk_prev  = clkout;
      ph_len    = 0;
      min_ph    = 1000000000;
      rises     = 0;
      since     = 0;
      last_per  = 0;
      have_rise = 1'b0;
      seen_edge = 1'b0;
   endtask

   task automatic track();
      since++;
      if (clkout !== trk_prev) begin
         if (seen_edge && ph_len < min_ph) min_ph = ph_len;
         seen_edge = 1'b1;
         ph_len = 1;
         if (clkout === 1'b1) begin
            rises++;
            if (have_rise) last_per = since;
            since = 0;
            have_rise = 1'b1;
         end
      end else begin
         ph_len++;
      end
      trk_prev = clkout;
   endtask

   // drive div for one edge, predict, then compare after the edge
   task automatic cycle(input logic [W-1:0] d);
      logic [W-1:0] e;
      div     = d;
      m_acc   = m_acc + m_div_q;
      m_div_q = d;
      exp_q.push_back(m_acc);
      @(posedge clkin);
      #1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         chk("clkout", clkout, e[W-1]);
         chk("acc", dut.acc, e);
      end
      track();
   endtask

   task automatic run(input logic [W-1:0] d, input int n);
      for (int i = 0; i < n; i++) cycle(d);
   endtask

   // assert reset asynchronously, hold 10 edges with d applied, release
   task automatic do_reset(input logic [W-1:0] d);
      reset_n = 1'b0;
      div     = d;
      m_acc   = '0;
      m_div_q = '0;
      exp_q.delete();
      #1;
      chk("rst_async_clkout", clkout, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clkin);
         #1;
         chk("rst_clkout", clkout, 0);
         chk("rst_acc", dut.acc, 0);
      end
      reset_n = 1'b1;
      chk("release_clkout", clkout, 0);
      track_reset();
   endtask

   task automatic freq_test(input string tag, input logic [W-1:0] d,
                            input int n);
      longint unsigned ex;
      do_reset(d);
      run(d, n);
      ex = (longint'(n - 1) * longint'(d)) >> W;
      $display("%s: rises %0d, nominal %0d", tag, rises, ex);
      chk(tag, (rises + 1 >= ex) && (rises <= ex + 1), 1);
   endtask

   initial begin
      logic [7:0] seq;
      bit         found;
      reset_n = 1'b0;
      div     = '0;
      m_acc   = '0;
      m_div_q = '0;

      // reset then release with div = 2^30
      do_reset(32'h4000_0000);
      seq = '0;
      for (int i = 0; i < 8; i++) begin
         cycle(32'h4000_0000);
         seq = {seq[6:0], clkout};
         if (i == 0) chk("acc_edge1", dut.acc, 0);
         if (i == 1) chk("acc_edge2", dut.acc, 32'h4000_0000);
         if (i == 7) chk("acc_edge8", dut.acc, 32'hC000_0000);
      end
      chk("release_seq", seq, 8'b0011_0011);

      // half rate
      do_reset(32'h8000_0000);
      run(32'h8000_0000, 200);
      chk("half_rises", rises, 100);
      chk("half_min_phase", min_ph, 1);
      chk("half_period", last_per, 2);

      // frozen accumulator
      do_reset(32'h0);
      run(32'h0, 1000);
      chk("zero_rises", rises, 0);
      chk("zero_clkout", clkout, 0);

      // long-term edge counts
      freq_test("ntsc_rises", 32'd922441723, 10000);
      freq_test("pal_rises", 32'd914027882, 10000);

      // live retune 2^30 -> 2^29
      do_reset(32'h4000_0000);
      run(32'h4000_0000, 50);
      chk("pre_retune_period", last_per, 4);
      run(32'h2000_0000, 60);
      chk("retune_min_phase", min_ph >= 2, 1);
      chk("retune_period", last_per, 8);

      // asynchronous reset while clkout is high
      do_reset(32'h4000_0000);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         cycle(32'h4000_0000);
         if (clkout === 1'b1) found = 1'b1;
      end
      chk("async_found_high", found, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_mid_clkout", clkout, 0);
      chk("async_mid_acc", dut.acc, 0);

      // modulo wrap aliasing
      do_reset(32'hC000_0000);
      run(32'hC000_0000, 200);
      chk("wrap_rises", rises, 50);
      chk("wrap_period", last_per, 4);
      chk("wrap_no_x", $isunknown(dut.acc), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
